// File: rtl/saturate_pkg.sv
// Shared types and constant helpers for the streaming requantizer.
package saturate_pkg;

  typedef enum logic [1:0] {
    TRUNC     = 2'b00,
    HALF_UP   = 2'b01,
    HALF_EVEN = 2'b10,
    RSVD      = 2'b11
  } rmode_e;

  // One guard bit above the input so that rounding up can never wrap.
  function automatic int ext_width(int in_w);
    return in_w + 1;
  endfunction

  function automatic longint sat_max(int limit);
    return (longint'(1) <<< (limit - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(int limit);
    return -(longint'(1) <<< (limit - 1));
  endfunction

endpackage

// File: rtl/saturate_lane.sv
// One lane: shift/round on the input side, clamp on the stage-1 side.
module saturate_lane
  import saturate_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int LIMIT     = OUT_WIDTH,
  localparam int EW = ext_width(IN_WIDTH),
  localparam int SW = $clog2(IN_WIDTH)
) (
  input  logic signed [IN_WIDTH-1:0] x_i,
  input  logic        [SW-1:0]       shift_i,
  input  logic        [1:0]          mode_i,
  output logic signed [EW-1:0]       rnd_o,
  input  logic signed [EW-1:0]       v_i,
  output logic        [OUT_WIDTH-1:0] y_o,
  output logic                       hi_o,
  output logic                       lo_o
);

  localparam logic signed [EW-1:0] MAXV = EW'(sat_max(LIMIT));
  localparam logic signed [EW-1:0] MINV = EW'(sat_min(LIMIT));

  logic signed [EW-1:0]       xe, q;
  logic        [IN_WIDTH-1:0] mask, r, h;
  logic                       up;

  always_comb begin
    xe   = {x_i[IN_WIDTH-1], x_i};
    q    = xe >>> shift_i;
    mask = ~({IN_WIDTH{1'b1}} << shift_i);
    r    = x_i & mask;
    h    = {{(IN_WIDTH-1){1'b0}}, 1'b1} << (shift_i - SW'(1));
    up   = 1'b0;
    case (rmode_e'(mode_i))
      HALF_UP:   up = (r >= h);
      HALF_EVEN: up = (r > h) || ((r == h) && q[0]);
      default:   up = 1'b0;
    endcase
    if (shift_i == '0) up = 1'b0;
    rnd_o = q + EW'(up);
  end

  // In-range values fit in LIMIT <= OUT_WIDTH bits, so truncation keeps the sign extension.
  always_comb begin
    hi_o = (v_i > MAXV);
    lo_o = (v_i < MINV);
    if (hi_o)      y_o = OUT_WIDTH'(MAXV);
    else if (lo_o) y_o = OUT_WIDTH'(MINV);
    else           y_o = v_i[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/saturate_stream.sv
// Two-stage N-lane requantizer with valid/ready handshake and saturation monitor.
module saturate_stream
  import saturate_pkg::*;
#(
  parameter int N         = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int LIMIT     = OUT_WIDTH,
  parameter int CNT_WIDTH = 16,
  localparam int SW = $clog2(IN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*IN_WIDTH-1:0]  in_data,
  input  logic [SW-1:0]          in_shift,
  input  logic [1:0]             in_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N*OUT_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           sat_hi,
  output logic [N-1:0]           sat_lo,
  output logic [CNT_WIDTH-1:0]   sat_count,
  input  logic                   clear
);

  localparam int EW = ext_width(IN_WIDTH);

  logic [N-1:0][EW-1:0]        rnd, s1_q;
  logic [N-1:0][OUT_WIDTH-1:0] y, data_q;
  logic [N-1:0]                hi, lo, hi_q, lo_q, hi_d, lo_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [2:1]                  vld_pipe_q;
  logic                        s1_adv, s2_adv, sat_evt;

  for (genvar k = 0; k < N; k++) begin : g_lane
    saturate_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .LIMIT(LIMIT)) u_lane (
      .x_i    (in_data[k*IN_WIDTH +: IN_WIDTH]),
      .shift_i(in_shift),
      .mode_i (in_mode),
      .rnd_o  (rnd[k]),
      .v_i    (s1_q[k]),
      .y_o    (y[k]),
      .hi_o   (hi[k]),
      .lo_o   (lo[k])
    );
  end

  // Ready ripples back combinationally from out_ready; there is no skid buffer.
  assign s2_adv   = out_ready | ~vld_pipe_q[2];
  assign s1_adv   = s2_adv | ~vld_pipe_q[1];
  assign in_ready = s1_adv;
  assign sat_evt  = s2_adv & vld_pipe_q[1] & (|{hi, lo});

  // Clear first, then a same-cycle event lands on the cleared state.
  always_comb begin
    hi_d  = clear ? '0 : hi_q;
    lo_d  = clear ? '0 : lo_q;
    cnt_d = clear ? '0 : cnt_q;
    if (sat_evt) begin
      hi_d = hi_d | hi;
      lo_d = lo_d | lo;
      if (~&cnt_d) cnt_d = cnt_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      data_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe_q[1] <= in_valid;
        if (in_valid) s1_q <= rnd;
      end
      if (s2_adv) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) data_q <= y;
      end
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_pipe_q[2];
  assign sat_hi    = hi_q;
  assign sat_lo    = lo_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_saturate_stream.sv
// Bench for saturate_stream: a LIMIT=16 instance and a LIMIT=8/CNT_WIDTH=2 instance share stimulus.
module tb_saturate_stream;
  localparam int N = 4, IW = 32, OW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*IW-1:0] in_data;
  logic [4:0]      in_shift;
  logic [1:0]      in_mode;
  logic            in_valid, in_ready, in_ready_b, out_ready, clear;
  logic [N*OW-1:0] out_data, out_data_b;
  logic            out_valid, out_valid_b;
  logic [N-1:0]    sat_hi, sat_lo, sat_hi_b, sat_lo_b;
  logic [15:0]     sat_count;
  logic [1:0]      sat_count_b;

  saturate_stream #(.N(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LIMIT(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sat_hi(sat_hi), .sat_lo(sat_lo), .sat_count(sat_count), .clear(clear));

  saturate_stream #(.N(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LIMIT(8), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_shift(in_shift), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .sat_hi(sat_hi_b), .sat_lo(sat_lo_b), .sat_count(sat_count_b), .clear(clear));

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        chk_b;
  } exp_t;

  typedef struct packed {
    logic [127:0] x;
    logic [4:0]   sh;
    logic [1:0]   md;
    logic [63:0]  ya;
    logic [63:0]  yb;
    logic         cb;
  } vec_t;

  int    n_chk = 0, n_pass = 0;
  exp_t  sb[$];
  exp_t  cur_exp, pe;
  logic  last_acc = 1'b0, stall_prev = 1'b0, bp_chk = 1'b0, done;
  logic [63:0] stall_data;
  vec_t  tv[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic longint m_round(longint x, int s, int m);
    longint q, r, h;
    logic up;
    if (s == 0) return x;
    q  = x >>> s;
    r  = x - (q <<< s);
    h  = longint'(1) <<< (s - 1);
    up = (m == 1 && r >= h) || (m == 2 && (r > h || (r == h && q[0])));
    return q + (up ? 64'sd1 : 64'sd0);
  endfunction

  function automatic logic [15:0] m_sat(longint v, int lim);
    longint mx, mn, t;
    mx = (longint'(1) <<< (lim - 1)) - 1;
    mn = -mx - 1;
    t  = (v > mx) ? mx : (v < mn) ? mn : v;
    return t[15:0];
  endfunction

  function automatic exp_t m_exp(logic [127:0] d, int s, int m);
    exp_t   e;
    longint v;
    for (int k = 0; k < N; k++) begin
      v = longint'($signed(d[k*32 +: 32]));
      v = m_round(v, s, m);
      e.a[k*16 +: 16] = m_sat(v, 16);
      e.b[k*16 +: 16] = m_sat(v, 8);
    end
    e.chk_b = 1'b1;
    return e;
  endfunction

  function automatic logic [127:0] L4(int a, int b, int c, int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] O4(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic vec_t mkv(logic [127:0] x, int sh, int md, logic [63:0] ya, logic [63:0] yb, logic cb);
    vec_t v;
    v.x = x; v.sh = 5'(sh); v.md = 2'(md); v.ya = ya; v.yb = yb; v.cb = cb;
    return v;
  endfunction

  function automatic exp_t tv_exp(vec_t v);
    exp_t e;
    e.a = v.ya; e.b = v.yb; e.chk_b = v.cb;
    return e;
  endfunction

  // Monitor: checks ready/stall behaviour, pops on transfer, pushes on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_acc   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (bp_chk) chk("in_ready", 64'(in_ready), 64'(!(!out_ready && sb.size() == 2)));
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", out_data, stall_data);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          pe = sb.pop_front();
          chk("out_data", out_data, pe.a);
          if (pe.chk_b) chk("out_data_b", out_data_b, pe.b);
        end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) sb.push_back(cur_exp);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [127:0] d, input int sh, input int md, input exp_t e);
    int n;
    in_data = d; in_shift = 5'(sh); in_mode = 2'(md); cur_exp = e; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) chk("accept_timeout", 64'(n), 64'd0);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0;
    out_ready = 1'b1; clear = 1'b0;

    tv[0] = mkv(L4(65536, -16, 0, 15), 4, 0, O4(4096, -1, 0, 0), '0, 1'b0);
    tv[1] = mkv(L4(40, -24, 24, 0), 4, 0, O4(2, -2, 1, 0), '0, 1'b0);
    tv[2] = mkv(L4(40, -24, 24, 0), 4, 1, O4(3, -1, 2, 0), '0, 1'b0);
    tv[3] = mkv(L4(40, -24, 24, 0), 4, 2, O4(2, -2, 2, 0), '0, 1'b0);
    tv[4] = mkv(L4(40, -24, 24, 0), 4, 3, O4(2, -2, 1, 0), '0, 1'b0);
    tv[5] = mkv(L4(32'h7FFFFFFF, 32'h80000000, -1, 32'h40000000), 31, 1, O4(1, -1, 0, 1), '0, 1'b0);
    tv[6] = mkv(L4(3, 5, -3, -1), 1, 2, O4(2, 2, -2, 0), '0, 1'b0);
    tv[7] = mkv(L4(-5, 7, -32768, 32767), 0, 2, O4(-5, 7, -32768, 32767), '0, 1'b0);
    tv[8] = mkv(L4(32'h7FFFFFFF, 32'h80000000, 32767, -32768), 0, 0,
                O4(32767, -32768, 32767, -32768), O4(127, -128, 127, -128), 1'b1);
    tv[9] = mkv(L4(200, -200, 127, -128), 0, 1,
                O4(200, -200, 127, -128), O4(127, -128, 127, -128), 1'b1);

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_sat_hi", 64'(sat_hi), 64'd0);
    chk("rst_sat_lo", 64'(sat_lo), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency: not valid after the accepting edge, valid after the next one.
    send(tv[0].x, 4, 0, tv_exp(tv[0]));
    chk("lat_edge1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 64'(out_valid), 64'd1);
    chk("nosat_hi", 64'(sat_hi), 64'd0);
    chk("nosat_lo", 64'(sat_lo), 64'd0);
    chk("nosat_cnt", 64'(sat_count), 64'd0);

    pulse_clear();
    for (int i = 0; i < 10; i++) send(tv[i].x, int'(tv[i].sh), int'(tv[i].md), tv_exp(tv[i]));
    repeat (4) @(posedge clk); #1;
    chk("tbl_sat_hi", 64'(sat_hi), 64'b0001);
    chk("tbl_sat_lo", 64'(sat_lo), 64'b0010);
    chk("tbl_sat_cnt", 64'(sat_count), 64'd1);

    // Counter saturation on the 2-bit instance.
    pulse_clear();
    for (int i = 0; i < 5; i++) send(tv[8].x, 0, 0, m_exp(tv[8].x, 0, 0));
    repeat (4) @(posedge clk); #1;
    chk("cnt_a_5", 64'(sat_count), 64'd5);
    chk("cnt_b_hold", 64'(sat_count_b), 64'd3);
    chk("b_sat_hi", 64'(sat_hi_b), 64'b0101);
    chk("b_sat_lo", 64'(sat_lo_b), 64'b1010);

    // Clear on the same edge the clamping beat enters stage 2.
    d = L4(0, 0, 32'h80000000, 32'h7FFFFFFF);
    send(d, 0, 0, m_exp(d, 0, 0));
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clr_evt_cnt", 64'(sat_count), 64'd1);
    chk("clr_evt_hi", 64'(sat_hi), 64'b1000);
    chk("clr_evt_lo", 64'(sat_lo), 64'b0100);
    pulse_clear();
    chk("clr_cnt", 64'(sat_count), 64'd0);
    chk("clr_hi", 64'(sat_hi), 64'd0);

    // Backpressure with a random stall pattern.
    bp_chk = 1'b1;
    done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [127:0] rd;
          int rs, rm;
          rd = {$urandom, $urandom, $urandom, $urandom};
          rs = int'($urandom_range(0, 31));
          rm = int'($urandom_range(0, 3));
          send(rd, rs, rm, m_exp(rd, rs, rm));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) == 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    bp_chk = 1'b0;
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages occupied and stalled.
    out_ready = 1'b0;
    send(tv[1].x, 4, 0, tv_exp(tv[1]));
    send(tv[2].x, 4, 1, tv_exp(tv[2]));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale", 64'(seen), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
